// File: rtl/dfd_tn_pkg.sv
// Shared types for the trace tail: source codes, buffer entry, flush states.
package dfd_tn_pkg;

  localparam logic TR_SRC_NTRACE = 1'b0;
  localparam logic TR_SRC_DST    = 1'b1;

  localparam int TN_DATA_W = 128;

  typedef struct packed {
    logic [1:0]           core;
    logic [TN_DATA_W-1:0] data;
  } tn_entry_t;

  typedef enum logic [1:0] {
    FL_IDLE   = 2'd0,
    FL_ASSERT = 2'd1,
    FL_DONE   = 2'd2
  } flush_state_e;

  function automatic logic [1:0] lowest_core(input logic [3:0] vld);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vld[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dfd_trace_tail_fifo.sv
// Synchronous FIFO with occupancy count; head entry shown on rdata.
module dfd_trace_tail_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; consumers gate it with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dfd_trace_tail.sv
// Trace chain endpoint: sorts beats into ntrace/dst buffers, drives bp/flush.
// Optional error checks enabled by DFD_TRACE_TAIL_ERR_CHK_EN.
module dfd_trace_tail
  import dfd_tn_pkg::*;
#(
  parameter int NUM_CORES_IN_PATH   = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
  parameter int FIFO_DEPTH          = 16,
  parameter int BP_SLACK            = 8,
  parameter int FLUSH_QUIET         = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CORES_IN_PATH-1:0] upstrm_tr_vld,
  input  logic                         upstrm_tr_src,
  input  logic [DATA_WIDTH-1:0]        upstrm_tr_data,
  output logic                         upstrm_tr_ntrace_bp,
  output logic                         upstrm_tr_dst_bp,
  output logic                         upstrm_tr_ntrace_flush,
  output logic                         upstrm_tr_dst_flush,
  output logic [NUM_CORES_IN_PATH-1:0] upstrm_tr_enabled_srcs,
  input  logic [NUM_CORES_IN_PATH-1:0] cfg_enabled_srcs,
  input  logic                         cfg_ntrace_flush_req,
  input  logic                         cfg_dst_flush_req,
  output logic                         ntrace_flush_done,
  output logic                         dst_flush_done,
  output logic                         ntrace_out_vld,
  input  logic                         ntrace_out_rdy,
  output logic [1:0]                   ntrace_out_core,
  output logic [DATA_WIDTH-1:0]        ntrace_out_data,
  output logic                         dst_out_vld,
  input  logic                         dst_out_rdy,
  output logic [1:0]                   dst_out_core,
  output logic [DATA_WIDTH-1:0]        dst_out_data,
  output logic                         err_onehot,
  output logic                         err_overflow,
  input  logic                         err_clr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = $clog2(FLUSH_QUIET + 1);
  localparam int EW = $bits(tn_entry_t);

  tn_entry_t    wr_ent;
  tn_entry_t    head [2];
  logic [CW-1:0] cnt [2];
  logic [1:0]   push, pop, full, empty, rdy, req, src_beat;
  logic         beat;

  logic [1:0]   bp_q, bp_d;
  logic [NUM_CORES_IN_PATH-1:0] en_q, en_d;

  flush_state_e fl_state_q [2];
  flush_state_e fl_state_d [2];
  logic [QW-1:0] quiet_q [2];
  logic [QW-1:0] quiet_d [2];
  logic [1:0]   req_q, req_d;
  logic [1:0]   done_q, done_d;

  assign beat = |upstrm_tr_vld;

  always_comb begin
    wr_ent      = '0;
    wr_ent.core = lowest_core(4'(upstrm_tr_vld));
    wr_ent.data = TN_DATA_W'(upstrm_tr_data);
  end

  assign src_beat[0] = beat & (upstrm_tr_src == TR_SRC_NTRACE);
  assign src_beat[1] = beat & (upstrm_tr_src == TR_SRC_DST);
  assign rdy[0]      = ntrace_out_rdy;
  assign rdy[1]      = dst_out_rdy;
  assign req[0]      = cfg_ntrace_flush_req;
  assign req[1]      = cfg_dst_flush_req;

  // Full buffers drop the beat even if a pop frees a slot this cycle.
  assign push = src_beat & ~full;
  assign pop  = rdy & ~empty;

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [EW-1:0] rd_raw;
    dfd_trace_tail_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[s]),
      .pop     (pop[s]),
      .wdata   (wr_ent),
      .rdata   (rd_raw),
      .empty   (empty[s]),
      .full    (full[s]),
      .count   (cnt[s])
    );
    assign head[s] = empty[s] ? '0 : tn_entry_t'(rd_raw);
  end

  assign ntrace_out_vld  = ~empty[0];
  assign ntrace_out_core = head[0].core;
  assign ntrace_out_data = head[0].data[DATA_WIDTH-1:0];
  assign dst_out_vld     = ~empty[1];
  assign dst_out_core    = head[1].core;
  assign dst_out_data    = head[1].data[DATA_WIDTH-1:0];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      bp_d[s] = (cnt[s] >= CW'(FIFO_DEPTH - BP_SLACK));
    end
    en_d = cfg_enabled_srcs;
  end

  assign upstrm_tr_ntrace_bp    = bp_q[0];
  assign upstrm_tr_dst_bp       = bp_q[1];
  assign upstrm_tr_enabled_srcs = en_q;

  always_comb begin
    req_d = req;
    for (int s = 0; s < 2; s++) begin
      fl_state_d[s] = fl_state_q[s];
      quiet_d[s]    = quiet_q[s];
      done_d[s]     = 1'b0;
      unique case (fl_state_q[s])
        FL_IDLE: begin
          quiet_d[s] = '0;
          if (req[s] && !req_q[s]) fl_state_d[s] = FL_ASSERT;
        end
        FL_ASSERT: begin
          if (!req[s]) begin
            fl_state_d[s] = FL_IDLE;
            quiet_d[s]    = '0;
          end else begin
            // Any beat in flight or still buffered restarts the quiet window.
            if (src_beat[s] || !empty[s]) quiet_d[s] = '0;
            else                          quiet_d[s] = quiet_q[s] + 1'b1;
            if (quiet_d[s] == QW'(FLUSH_QUIET)) begin
              fl_state_d[s] = FL_DONE;
              done_d[s]     = 1'b1;
            end
          end
        end
        FL_DONE: begin
          quiet_d[s] = '0;
          if (!req[s]) fl_state_d[s] = FL_IDLE;
        end
        default: begin
          fl_state_d[s] = FL_IDLE;
          quiet_d[s]    = '0;
        end
      endcase
    end
  end

  assign upstrm_tr_ntrace_flush = (fl_state_q[0] == FL_ASSERT);
  assign upstrm_tr_dst_flush    = (fl_state_q[1] == FL_ASSERT);
  assign ntrace_flush_done      = done_q[0];
  assign dst_flush_done         = done_q[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bp_q   <= '0;
      en_q   <= '0;
      req_q  <= '0;
      done_q <= '0;
      for (int s = 0; s < 2; s++) begin
        fl_state_q[s] <= FL_IDLE;
        quiet_q[s]    <= '0;
      end
    end else begin
      bp_q   <= bp_d;
      en_q   <= en_d;
      req_q  <= req_d;
      done_q <= done_d;
      for (int s = 0; s < 2; s++) begin
        fl_state_q[s] <= fl_state_d[s];
        quiet_q[s]    <= quiet_d[s];
      end
    end
  end

`ifdef DFD_TRACE_TAIL_ERR_CHK_EN
  logic multi_hot, ovf;
  logic err_onehot_q, err_onehot_d;
  logic err_overflow_q, err_overflow_d;

  assign multi_hot = |(upstrm_tr_vld & (upstrm_tr_vld - NUM_CORES_IN_PATH'(1)));
  assign ovf       = |(src_beat & full);

  // A new error in the same cycle as err_clr wins.
  always_comb begin
    err_onehot_d   = (err_onehot_q & ~err_clr) | multi_hot;
    err_overflow_d = (err_overflow_q & ~err_clr) | ovf;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_onehot_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      err_onehot_q   <= err_onehot_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_onehot   = err_onehot_q;
  assign err_overflow = err_overflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_onehot     = 1'b0;
  assign err_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_dfd_trace_tail.sv
// Directed bench for dfd_trace_tail: routing, bp, overflow, flush, reset.
module tb_dfd_trace_tail;

`ifdef DFD_TRACE_TAIL_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic [3:0]   upstrm_tr_vld;
  logic         upstrm_tr_src;
  logic [127:0] upstrm_tr_data;
  logic         upstrm_tr_ntrace_bp;
  logic         upstrm_tr_dst_bp;
  logic         upstrm_tr_ntrace_flush;
  logic         upstrm_tr_dst_flush;
  logic [3:0]   upstrm_tr_enabled_srcs;
  logic [3:0]   cfg_enabled_srcs;
  logic         cfg_ntrace_flush_req;
  logic         cfg_dst_flush_req;
  logic         ntrace_flush_done;
  logic         dst_flush_done;
  logic         ntrace_out_vld;
  logic         ntrace_out_rdy;
  logic [1:0]   ntrace_out_core;
  logic [127:0] ntrace_out_data;
  logic         dst_out_vld;
  logic         dst_out_rdy;
  logic [1:0]   dst_out_core;
  logic [127:0] dst_out_data;
  logic         err_onehot;
  logic         err_overflow;
  logic         err_clr;

  int n_chk;
  int n_pass;
  int n;
  logic saw;

  dfd_trace_tail dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .upstrm_tr_vld          (upstrm_tr_vld),
    .upstrm_tr_src          (upstrm_tr_src),
    .upstrm_tr_data         (upstrm_tr_data),
    .upstrm_tr_ntrace_bp    (upstrm_tr_ntrace_bp),
    .upstrm_tr_dst_bp       (upstrm_tr_dst_bp),
    .upstrm_tr_ntrace_flush (upstrm_tr_ntrace_flush),
    .upstrm_tr_dst_flush    (upstrm_tr_dst_flush),
    .upstrm_tr_enabled_srcs (upstrm_tr_enabled_srcs),
    .cfg_enabled_srcs       (cfg_enabled_srcs),
    .cfg_ntrace_flush_req   (cfg_ntrace_flush_req),
    .cfg_dst_flush_req      (cfg_dst_flush_req),
    .ntrace_flush_done      (ntrace_flush_done),
    .dst_flush_done         (dst_flush_done),
    .ntrace_out_vld         (ntrace_out_vld),
    .ntrace_out_rdy         (ntrace_out_rdy),
    .ntrace_out_core        (ntrace_out_core),
    .ntrace_out_data        (ntrace_out_data),
    .dst_out_vld            (dst_out_vld),
    .dst_out_rdy            (dst_out_rdy),
    .dst_out_core           (dst_out_core),
    .dst_out_data           (dst_out_data),
    .err_onehot             (err_onehot),
    .err_overflow           (err_overflow),
    .err_clr                (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_n = 1'b0;
    upstrm_tr_vld = '0;
    upstrm_tr_src = 1'b0;
    upstrm_tr_data = '0;
    cfg_enabled_srcs = '0;
    cfg_ntrace_flush_req = 1'b0;
    cfg_dst_flush_req = 1'b0;
    ntrace_out_rdy = 1'b0;
    dst_out_rdy = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();

    chk("rst_nt_vld", ntrace_out_vld, 0);
    chk("rst_dst_vld", dst_out_vld, 0);
    chk("rst_nt_data", ntrace_out_data, 0);
    chk("rst_nt_bp", upstrm_tr_ntrace_bp, 0);
    chk("rst_dst_bp", upstrm_tr_dst_bp, 0);
    chk("rst_nt_fl", upstrm_tr_ntrace_flush, 0);
    chk("rst_en", upstrm_tr_enabled_srcs, 0);
    chk("rst_err", {err_onehot, err_overflow}, 0);

    reset_n = 1'b1;
    tick();

    // core 2 streams five ntrace beats straight through
    ntrace_out_rdy = 1'b1;
    dst_out_rdy = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      upstrm_tr_vld = 4'b0100;
      upstrm_tr_src = 1'b0;
      upstrm_tr_data = 128'(i);
      tick();
      chk("t1_vld", ntrace_out_vld, 1);
      chk("t1_core", ntrace_out_core, 2);
      chk("t1_data", ntrace_out_data, 128'(i));
    end
    upstrm_tr_vld = '0;
    tick();
    chk("t1_empty", ntrace_out_vld, 0);

    cfg_enabled_srcs = 4'b1010;
    chk("en_before", upstrm_tr_enabled_srcs, 0);
    tick();
    chk("en_after", upstrm_tr_enabled_srcs, 4'b1010);

    // stalled ntrace fills up
    ntrace_out_rdy = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      upstrm_tr_vld = 4'b0010;
      upstrm_tr_src = 1'b0;
      upstrm_tr_data = 128'(32'h100 + i);
      tick();
      if (i == 8)  chk("bp_8", upstrm_tr_ntrace_bp, 0);
      if (i == 9)  chk("bp_9", upstrm_tr_ntrace_bp, 1);
      if (i == 16) chk("ovf_16", err_overflow, 0);
      if (i == 17) chk("ovf_17", err_overflow, ERR_EXP);
    end
    chk("fill_head", ntrace_out_data, 128'h101);
    chk("fill_core", ntrace_out_core, 1);

    for (int i = 1; i <= 3; i++) begin
      upstrm_tr_vld = 4'b1000;
      upstrm_tr_src = 1'b1;
      upstrm_tr_data = 128'(32'h200 + i);
      tick();
      chk("dst_data", dst_out_data, 128'(32'h200 + i));
      chk("dst_core", dst_out_core, 3);
      chk("dst_bp", upstrm_tr_dst_bp, 0);
      chk("nt_bp_hold", upstrm_tr_ntrace_bp, 1);
    end
    upstrm_tr_vld = '0;
    tick();
    chk("dst_empty", dst_out_vld, 0);

    ntrace_out_rdy = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      chk("drain", ntrace_out_data, 128'(32'h100 + j));
      tick();
    end
    chk("drain_empty", ntrace_out_vld, 0);
    chk("drain_bp", upstrm_tr_ntrace_bp, 0);
    chk("ovf_sticky", err_overflow, ERR_EXP);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", err_overflow, 0);

    // multi-hot beat lands under the lowest core
    dst_out_rdy = 1'b0;
    upstrm_tr_vld = 4'b0101;
    upstrm_tr_src = 1'b1;
    upstrm_tr_data = 128'hAB;
    tick();
    upstrm_tr_vld = '0;
    chk("oh_err", err_onehot, ERR_EXP);
    chk("oh_core", dst_out_core, 0);
    chk("oh_data", dst_out_data, 128'hAB);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("oh_clr", err_onehot, 0);
    chk("oh_hold", dst_out_data, 128'hAB);
    dst_out_rdy = 1'b1;
    tick();
    chk("oh_pop", dst_out_vld, 0);

    // quiet flush
    cfg_ntrace_flush_req = 1'b1;
    chk("fl_pre", upstrm_tr_ntrace_flush, 0);
    tick();
    chk("fl_rise", upstrm_tr_ntrace_flush, 1);
    n = 0;
    while (n < 30 && !ntrace_flush_done) begin
      tick();
      n++;
    end
    chk("fl_cycles", 128'(n), 8);
    chk("fl_done_low", upstrm_tr_ntrace_flush, 0);
    tick();
    chk("fl_pulse1", ntrace_flush_done, 0);

    // beat at quiet count 4 restarts the window
    cfg_ntrace_flush_req = 1'b0;
    tick();
    cfg_ntrace_flush_req = 1'b1;
    tick();
    chk("fl2_rise", upstrm_tr_ntrace_flush, 1);
    repeat (4) tick();
    upstrm_tr_vld = 4'b0001;
    upstrm_tr_src = 1'b0;
    upstrm_tr_data = 128'h55;
    tick();
    upstrm_tr_vld = '0;
    n = 5;
    chk("fl2_beat", ntrace_out_data, 128'h55);
    while (n < 40 && !ntrace_flush_done) begin
      tick();
      n++;
    end
    chk("fl2_cycles", 128'(n), 14);
    cfg_ntrace_flush_req = 1'b0;
    tick();

    // reset during a dst flush with data buffered
    ntrace_out_rdy = 1'b0;
    dst_out_rdy = 1'b0;
    upstrm_tr_vld = 4'b0010;
    upstrm_tr_src = 1'b1;
    upstrm_tr_data = 128'h77;
    cfg_dst_flush_req = 1'b1;
    tick();
    chk("rf_fl", upstrm_tr_dst_flush, 1);
    chk("rf_vld", dst_out_vld, 1);
    upstrm_tr_vld = 4'b0001;
    upstrm_tr_src = 1'b0;
    upstrm_tr_data = 128'h66;
    tick();
    upstrm_tr_vld = '0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("rf_fl0", upstrm_tr_dst_flush, 0);
    chk("rf_dvld0", dst_out_vld, 0);
    chk("rf_nvld0", ntrace_out_vld, 0);
    chk("rf_data0", dst_out_data, 0);
    chk("rf_en0", upstrm_tr_enabled_srcs, 0);
    saw = dst_flush_done;
    repeat (10) begin
      tick();
      if (dst_flush_done) saw = 1'b1;
    end
    chk("rf_nodone", saw, 0);
    cfg_dst_flush_req = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rf_post", dst_out_vld, 0);
    chk("rf_post_fl", upstrm_tr_dst_flush, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
